// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_pkg
// Brief   : Shared size/state encodings and lane helpers for the load/store unit
// Revision: 1.0
// ============================================================================
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10,
        ERR  = 2'b11
    } state_e;

    function automatic int lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit_if
// Brief   : Shared memory bus (breq_/bgrt_ arbitration, lane-enabled data)
// Revision: 1.0
// ============================================================================
interface mem_access_unit_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int BUS_ADDR_WIDTH = 10
);
    logic                        breq_;
    logic                        bgrt_;
    logic                        memread;
    logic                        memwrite;
    logic [BUS_ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]       writedata;
    logic [DATA_WIDTH/8-1:0]     byteen;
    logic [DATA_WIDTH-1:0]       memdata;

    modport master (
        output breq_, memread, memwrite, adr, writedata, byteen,
        input  bgrt_, memdata
    );

    modport slave (
        input  breq_, memread, memwrite, adr, writedata, byteen,
        output bgrt_, memdata
    );
endinterface
`default_nettype wire

// File: rtl/mau_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : mau_lane_align
// Brief   : Store lane replication, byte-enable generation, load extract/extend
// Revision: 1.0
// ============================================================================
module mau_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire size_e                              size,
    input  wire logic [$clog2(DATA_WIDTH/8)-1:0]    offset,
    input  wire logic                               is_signed,
    input  wire logic [DATA_WIDTH-1:0]              wdata,
    input  wire logic [DATA_WIDTH-1:0]              rdata,
    output logic      [DATA_WIDTH-1:0]              wdata_lanes,
    output logic      [DATA_WIDTH/8-1:0]            byteen,
    output logic      [DATA_WIDTH-1:0]              rdata_ext
);
    localparam int c_lanes = lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_word_rep;
    logic [DATA_WIDTH-1:0] w_word_ext;
    logic [c_lanes-1:0]    w_word_be;

    // Keep the low nbits and either sign-fill or zero-fill the rest.
    function automatic logic [DATA_WIDTH-1:0] extend(
        input logic [DATA_WIDTH-1:0] value,
        input int                    nbits,
        input logic                  sgn
    );
        logic [DATA_WIDTH-1:0] keep;
        keep = ~({DATA_WIDTH{1'b1}} << nbits);
        return (sgn && value[nbits-1]) ? (value | ~keep) : (value & keep);
    endfunction

    assign w_shifted = rdata >> {offset, 3'b000};

    generate
        if (DATA_WIDTH >= 32) begin : g_word
            assign w_word_rep = {(DATA_WIDTH/32){wdata[31:0]}};
            assign w_word_be  = c_lanes'(4'hF) << offset;
            assign w_word_ext = extend(w_shifted, 32, is_signed);
        end else begin : g_no_word
            assign w_word_rep = '0;
            assign w_word_be  = '0;
            assign w_word_ext = '0;
        end
    endgenerate

    always_comb begin
        wdata_lanes = '0;
        byteen      = '0;
        rdata_ext   = '0;
        case (size)
            SZ_BYTE: begin
                wdata_lanes = {c_lanes{wdata[7:0]}};
                byteen      = c_lanes'(1) << offset;
                rdata_ext   = extend(w_shifted, 8, is_signed);
            end
            SZ_HALF: begin
                wdata_lanes = {(c_lanes/2){wdata[15:0]}};
                byteen      = c_lanes'(2'b11) << offset;
                rdata_ext   = extend(w_shifted, 16, is_signed);
            end
            SZ_WORD: begin
                wdata_lanes = w_word_rep;
                byteen      = w_word_be;
                rdata_ext   = w_word_ext;
            end
            default: begin
                wdata_lanes = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Brief   : Single-outstanding load/store bus master; MAU_TIMEOUT_EN adds a
//           grant-wait timeout that ends the access with rsp_err.
// Revision: 1.0
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_ADDR_WIDTH = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic                   clk,
    input  wire logic                   reset_,
    input  wire logic                   req_valid,
    output logic                        req_ready,
    input  wire logic                   req_we,
    input  wire logic [1:0]             req_size,
    input  wire logic                   req_signed,
    input  wire logic [ADDR_WIDTH-1:0]  req_adr,
    input  wire logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                        rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_err,
    mem_access_unit_if.master           bus
);
    localparam int c_lanes = lanes(DATA_WIDTH);
    localparam int c_lb    = $clog2(c_lanes);

    state_e                     r_state, w_next;
    logic                       r_we, r_signed;
    size_e                      r_size;
    logic [c_lb-1:0]            r_offset;
    logic [BUS_ADDR_WIDTH-1:0]  r_adr;
    logic [DATA_WIDTH-1:0]      r_wdata, r_rdata;
    logic [c_lanes-1:0]         r_byteen;

    logic [c_lb-1:0]            w_offset, w_al_offset;
    size_e                      w_al_size;
    logic                       w_misaligned, w_accept, w_grant, w_timeout, w_unused;
    logic [DATA_WIDTH-1:0]      w_wdata_lanes, w_rdata_ext;
    logic [c_lanes-1:0]         w_byteen;

    assign w_offset = req_adr[c_lb-1:0];
    assign w_accept = req_valid && (r_state == IDLE);
    assign w_grant  = (r_state == BUS) && !bus.bgrt_;
    assign w_unused = &{1'b0, req_adr, 32'(TIMEOUT_CYCLES)};

    always_comb begin
        w_misaligned = 1'b0;
        case (size_e'(req_size))
            SZ_HALF: w_misaligned = w_offset[0];
            SZ_WORD: w_misaligned = (DATA_WIDTH < 32) || (w_offset != '0);
            SZ_ILL:  w_misaligned = 1'b1;
            default: w_misaligned = 1'b0;
        endcase
    end

    // While idle the aligner steers the incoming request; afterwards it
    // extracts load data using the captured size and offset.
    assign w_al_size   = (r_state == IDLE) ? size_e'(req_size) : r_size;
    assign w_al_offset = (r_state == IDLE) ? w_offset : r_offset;

    mau_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .size        (w_al_size),
        .offset      (w_al_offset),
        .is_signed   (r_signed),
        .wdata       (req_wdata),
        .rdata       (bus.memdata),
        .wdata_lanes (w_wdata_lanes),
        .byteen      (w_byteen),
        .rdata_ext   (w_rdata_ext)
    );

`ifdef MAU_TIMEOUT_EN
    localparam int c_to_w = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [c_to_w-1:0] r_wait;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wait <= '0;
        end else if (r_state != BUS) begin
            r_wait <= '0;
        end else if (bus.bgrt_) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // A grant on the limit cycle takes priority in the next-state logic.
    assign w_timeout = (r_state == BUS) && (r_wait == c_to_w'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        bus.breq_    = 1'b1;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_misaligned ? ERR : BUS;
                end
            end
            BUS: begin
                bus.breq_    = 1'b0;
                bus.memread  = !r_we;
                bus.memwrite = r_we;
                if (!bus.bgrt_) begin
                    w_next = RESP;
                end else if (w_timeout) begin
                    w_next = ERR;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= SZ_BYTE;
            r_offset <= '0;
            r_adr    <= '0;
            r_wdata  <= '0;
            r_byteen <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= req_we;
                r_signed <= req_signed;
                r_size   <= size_e'(req_size);
                r_offset <= w_offset;
                r_adr    <= req_adr[BUS_ADDR_WIDTH+c_lb-1:c_lb];
                r_wdata  <= w_wdata_lanes;
                r_byteen <= w_byteen;
            end
            if (w_grant) begin
                r_rdata <= r_we ? '0 : w_rdata_ext;
            end else if (w_next == ERR) begin
                r_rdata <= '0;
            end
        end
    end

    assign bus.adr       = r_adr;
    assign bus.writedata = r_wdata;
    assign bus.byteen    = r_byteen;
    assign rsp_rdata     = r_rdata;

endmodule
`default_nettype wire
